kan_layer_sequencer: RTL and testbench
======================================

// Module: kan_layer_sequencer
// PURPOSE
//  Time-multiplexed controller for one KAN layer: out = sat8((sum_j x[j]*(base[i][j]+spline[i][j])) >>> SCALE_SHIFT).
//  Replaces the fully parallel layer datapath. Walks the weight BRAMs row by row with one shared MAC pair.
//  Sits between the input feature buffer, the base/spline weight ROMs and the next layer's input buffer.
//  Driven by start/done from the network-level controller.
// PARAMETERS
//  IN_FEATURES   784  inputs per neuron (>=2)
//  OUT_FEATURES  64   neurons in the layer (>=1)
//  SCALE_SHIFT   8    quantisation shift (SCALE=256 -> 8)
//  ACC_W         32   accumulator width, signed
//  IDX_W / ADDR_W     $clog2(IN_FEATURES) / $clog2(IN_FEATURES*OUT_FEATURES)
// PORTS
//  clk        in   1       clock; single clock domain
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse; sampled only in IDLE
//  busy       out  1       high from cycle after accepted start until DONE
//  done       out  1       1-cycle pulse after last neuron written
//  in_addr    out  IDX_W   feature buffer read address
//  in_data    in   8       unsigned feature; valid 1 cycle after in_addr
//  w_addr     out  ADDR_W  weight ROM address = i*IN_FEATURES+j
//  base_w     in   16      signed base weight; valid 1 cycle after w_addr
//  spline_w   in   16      signed spline weight; valid 1 cycle after w_addr
//  out_valid  out  1       result valid
//  out_idx    out  6+      neuron index i ($clog2(OUT_FEATURES) bits)
//  out_data   out  8       unsigned saturated result
//  out_ready  in   1       consumer accepts when out_valid&&out_ready
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, out_valid=0; in_addr, w_addr, out_idx, out_data=0; acc=0; counters=0.
//  FSM: IDLE -> (start) ISSUE -> (j==IN_FEATURES-1) DRAIN -> SCALE -> WRITE -> (handshake)
//       ISSUE for next i | DONE when i==OUT_FEATURES-1 -> IDLE.
//  ISSUE: one address per cycle, j=0..IN_FEATURES-1; w_addr increments linearly and never resets between neurons.
//  MAC: data for address at cycle k is accumulated at cycle k+1.
//       acc <= acc + $signed({1'b0,in_data})*base_w + $signed({1'b0,in_data})*spline_w.
//  First ISSUE cycle of each neuron clears acc: accumulation of the previous neuron is fully drained first.
//  DRAIN: accumulates last product. SCALE: t = acc >>> SCALE_SHIFT (arithmetic).
//       out_data = t<0 ? 0 : t>255 ? 255 : t[7:0].
//  Products and acc are signed ACC_W; no accumulator overflow detection (ACC_W sized by integrator).
//  WRITE: out_valid=1, out_idx=i, out_data stable until out_ready. out_valid drops the cycle after handshake.
//  Latency per neuron: IN_FEATURES+3 cycles start-of-ISSUE to out_valid (ISSUE n, DRAIN, SCALE, then WRITE).
//  Zero-stall total: OUT_FEATURES*(IN_FEATURES+3) + 1 cycles from start to done.
//  Backpressure: out_ready low holds WRITE indefinitely; no addresses issued; acc unchanged.
//  start while busy: ignored, no effect. start coincident with done: ignored (DONE is not IDLE).
//  Address outputs are don't-care outside ISSUE but must hold last value (no toggling).
//  reset_n low mid-layer: immediate return to reset values; partial results are discarded; no done pulse.
// STRUCTURE
//  kan_pkg: state enum (IDLE, ISSUE, DRAIN, SCALE, WRITE, DONE), SAT_MAX=255, default widths.
//  Sub-module kan_mac_unit: 8x16 dual-product accumulate with clear/enable, ACC_W output.
//  Top level holds FSM, i/j counters, w_addr counter, scale/saturate logic and output register.
// TESTING (bench: IN_FEATURES=4, OUT_FEATURES=2, SCALE_SHIFT=8, ROM models with 1-cycle latency)
//  Basic: x=[1,2,3,4], base row0=256 each, spline row0=0 -> out_idx0 out_data=10.
//         Row1 base=0, spline=128 each -> out_data=5. done 15 cycles after start, out_ready=1.
//  Saturation: x=255 all, base=0x7FFF -> 255. Base=0x8000 -> 0. Result 255.99 (acc=0xFFFF) -> 255.
//  Backpressure: out_ready=0 for 10 cycles in WRITE.
//         out_valid/out_data/out_idx stable, w_addr frozen, final results match unstalled run.
//  Address walk: w_addr sequence 0..7 exactly once, in_addr 0..3 twice; start pulsed while busy changes nothing.
//  Reset mid-op: reset_n low during neuron1 ISSUE -> all outputs 0 next cycle.
//         A fresh start then reproduces the basic results.
//  Back-to-back: start on cycle after done -> second full run, identical outputs.

Source files
------------

// File: rtl/kan_pkg.sv
// rtl/kan_pkg.sv - shared state type, saturation limit and default widths for the KAN layer sequencer
package kan_pkg;

    localparam int DEF_IN_FEATURES  = 784;
    localparam int DEF_OUT_FEATURES = 64;
    localparam int DEF_SCALE_SHIFT  = 8;
    localparam int DEF_ACC_W        = 32;
    localparam int SAT_MAX          = 255;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SCALE,
        WRITE,
        DONE
    } state_t;

    // Keeps index ports at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kan_mac_unit.sv
// rtl/kan_mac_unit.sv - 8x16 dual-product multiply-accumulate with synchronous clear and enable
module kan_mac_unit #(
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [7:0]              x,
    input  logic signed [15:0]      base_w,
    input  logic signed [15:0]      spline_w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] base_ext;
    logic signed [ACC_W-1:0] spline_ext;
    logic signed [ACC_W-1:0] sum;

    // Feature is unsigned, weights are signed; widen both before multiplying.
    assign x_ext      = $signed({{(ACC_W-8){1'b0}}, x});
    assign base_ext   = {{(ACC_W-16){base_w[15]}}, base_w};
    assign spline_ext = {{(ACC_W-16){spline_w[15]}}, spline_w};
    assign sum        = acc + x_ext * base_ext + x_ext * spline_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/kan_layer_sequencer.sv
// rtl/kan_layer_sequencer.sv - time-multiplexed KAN layer controller walking weight ROMs with one shared MAC
module kan_layer_sequencer
    import kan_pkg::*;
#(
    parameter int IN_FEATURES  = DEF_IN_FEATURES,
    parameter int OUT_FEATURES = DEF_OUT_FEATURES,
    parameter int SCALE_SHIFT  = DEF_SCALE_SHIFT,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int IDX_W        = idx_width(IN_FEATURES),
    parameter int ADDR_W       = idx_width(IN_FEATURES * OUT_FEATURES),
    parameter int OIDX_W       = idx_width(OUT_FEATURES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         in_addr,
    input  logic [7:0]               in_data,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic signed [15:0]       base_w,
    input  logic signed [15:0]       spline_w,
    output logic                     out_valid,
    output logic [OIDX_W-1:0]        out_idx,
    output logic [7:0]               out_data,
    input  logic                     out_ready
);

    state_t                  state;
    state_t                  next_state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] scaled;
    logic [7:0]              sat_val;
    logic                    last_j;
    logic                    last_i;
    logic                    mac_clear;
    logic                    mac_en;

    // in_addr doubles as the feature counter j, out_idx as the neuron counter i.
    assign last_j = (in_addr == IDX_W'(IN_FEATURES - 1));
    assign last_i = (out_idx == OIDX_W'(OUT_FEATURES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                // Data on the bus lags the address by one cycle, so j==0 has nothing to add yet.
                mac_clear = (in_addr == '0);
                mac_en    = (in_addr != '0);
                if (last_j) next_state = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                mac_en     = 1'b1;
                next_state = SCALE;
            end
            SCALE: begin
                busy       = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = last_i ? DONE : ISSUE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        scaled = acc >>> SCALE_SHIFT;
        if (scaled[ACC_W-1]) begin
            sat_val = '0;
        end else if (scaled > $signed(ACC_W'(SAT_MAX))) begin
            sat_val = 8'(SAT_MAX);
        end else begin
            sat_val = scaled[7:0];
        end
    end

    // Addresses only move in ISSUE and on the WRITE->ISSUE hop; everywhere else they hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_addr  <= '0;
            w_addr   <= '0;
            out_idx  <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_addr <= '0;
                        w_addr  <= '0;
                        out_idx <= '0;
                    end
                end
                ISSUE: begin
                    if (!last_j) begin
                        in_addr <= in_addr + IDX_W'(1);
                        w_addr  <= w_addr + ADDR_W'(1);
                    end
                end
                SCALE: out_data <= sat_val;
                WRITE: begin
                    if (out_ready && !last_i) begin
                        out_idx <= out_idx + OIDX_W'(1);
                        in_addr <= '0;
                        w_addr  <= w_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    kan_mac_unit #(
        .ACC_W(ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mac_clear),
        .en      (mac_en),
        .x       (in_data),
        .base_w  (base_w),
        .spline_w(spline_w),
        .acc     (acc)
    );

endmodule

// File: tb/tb_kan_layer_sequencer.sv
// tb/tb_kan_layer_sequencer.sv - scoreboard bench for kan_layer_sequencer with ROM models and a reference model
module tb_kan_layer_sequencer;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int SH = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               busy;
    logic               done;
    logic [1:0]         in_addr;
    logic [7:0]         in_data;
    logic [2:0]         w_addr;
    logic signed [15:0] base_w;
    logic signed [15:0] spline_w;
    logic               out_valid;
    logic [0:0]         out_idx;
    logic [7:0]         out_data;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]         x_mem      [NI];
    logic signed [15:0] base_mem   [NI*NO];
    logic signed [15:0] spline_mem [NI*NO];

    typedef struct {
        int idx;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   wseq[$];
    int   iseq[$];

    logic       stalled_q = 1'b0;
    logic [7:0] hold_data;
    logic [0:0] hold_idx;
    logic [2:0] hold_waddr;

    kan_layer_sequencer #(
        .IN_FEATURES (NI),
        .OUT_FEATURES(NO),
        .SCALE_SHIFT (SH),
        .ACC_W       (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .base_w   (base_w),
        .spline_w (spline_w),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_data  <= x_mem[in_addr];
        base_w   <= base_mem[w_addr];
        spline_w <= spline_mem[w_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_neuron(input int i);
        longint s;
        s = 0;
        for (int j = 0; j < NI; j++)
            s += longint'(x_mem[j]) * (longint'(base_mem[i*NI+j]) + longint'(spline_mem[i*NI+j]));
        s = s >>> SH;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            check("out_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_idx", out_idx, e.idx);
                check("out_data", out_data, e.data);
            end
        end
        if (stalled_q) begin
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, hold_data);
            check("bp_idx_held", out_idx, hold_idx);
            check("bp_waddr_frozen", w_addr, hold_waddr);
        end
        stalled_q  = reset_n && out_valid && !out_ready;
        hold_data  = out_data;
        hold_idx   = out_idx;
        hold_waddr = w_addr;
        if (reset_n && busy) begin
            if (wseq.size() == 0 || wseq[$] != int'(w_addr)) wseq.push_back(int'(w_addr));
            if (iseq.size() == 0 || iseq[$] != int'(in_addr)) iseq.push_back(int'(in_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.idx  = i;
            e.data = ref_neuron(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_basic();
        for (int j = 0; j < NI; j++) begin
            x_mem[j]         = 8'(j + 1);
            base_mem[j]      = 16'sd256;
            spline_mem[j]    = 16'sd0;
            base_mem[NI+j]   = 16'sd0;
            spline_mem[NI+j] = 16'sd128;
        end
    endtask

    task automatic load_random();
        for (int j = 0; j < NI; j++) x_mem[j] = 8'($urandom);
        for (int k = 0; k < NI*NO; k++) begin
            base_mem[k]   = 16'($urandom);
            spline_mem[k] = 16'($urandom);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the done cycle.
    task automatic run_layer(input int stall, input bit poke_busy, input bit poke_done);
        int cycles;
        int stall_left;
        bit seen;
        push_expected(NO);
        wseq.delete();
        iseq.delete();
        stall_left = stall;
        cycles     = 0;
        seen       = 1'b0;
        out_ready  = 1'b1;
        start      = 1'b1;
        while (!seen && cycles < 400) begin
            tick();
            cycles++;
            start = poke_busy && (cycles == 3);
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("done_latency", cycles, NO*(NI+3) + 1 + stall);
        check("w_walk_len", wseq.size(), NI*NO);
        for (int k = 0; k < NI*NO; k++)
            check("w_walk", (k < wseq.size()) ? wseq[k] : -1, k);
        check("in_walk_len", iseq.size(), NI*NO);
        for (int k = 0; k < NI*NO; k++)
            check("in_walk", (k < iseq.size()) ? iseq[k] : -1, k % NI);
        if (poke_done) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_at_done_ignored", busy, 0);
        end
    endtask

    task automatic run_reset_mid();
        push_expected(1);
        out_ready = 1'b1;
        start     = 1'b1;
        for (int c = 1; c <= NI + 5; c++) begin
            tick();
            start = 1'b0;
        end
        check("mid_busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_outputs", {busy, done, out_valid, in_addr, w_addr, out_idx, out_data}, 0);
        check("mid_rst_queue_drained", exp_q.size(), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mid_rst_no_done", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        load_basic();
        repeat (3) tick();
        check("rst_outputs", {busy, done, out_valid, in_addr, w_addr, out_idx, out_data}, 0);
        reset_n = 1'b1;
        tick();

        run_layer(0, 1'b1, 1'b1);
        run_layer(0, 1'b0, 1'b0);
        tick();

        for (int j = 0; j < NI; j++) begin
            x_mem[j]         = 8'd255;
            base_mem[j]      = 16'sh7FFF;
            spline_mem[j]    = 16'sd0;
            base_mem[NI+j]   = 16'sh8000;
            spline_mem[NI+j] = 16'sd0;
        end
        run_layer(0, 1'b0, 1'b0);
        tick();

        load_random();
        x_mem[0] = 8'd255;
        for (int j = 1; j < NI; j++) x_mem[j] = 8'd0;
        base_mem[0] = 16'sd257;
        for (int j = 1; j < NI; j++) base_mem[j] = 16'sd0;
        for (int j = 0; j < NI; j++) spline_mem[j] = 16'sd0;
        run_layer(0, 1'b0, 1'b0);
        tick();

        load_basic();
        run_layer(10, 1'b0, 1'b0);
        tick();

        repeat (6) begin
            load_random();
            run_layer(int'($urandom_range(0, 3)), 1'b0, 1'b0);
            tick();
        end

        load_basic();
        run_reset_mid();
        run_layer(0, 1'b0, 1'b0);
        tick();

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
